// File: rtl/rv32i_types.sv
// Shared RV32I core types: register/ROB index widths and the memory-op queue entry.
package rv32i_types;

    localparam int RV_XLEN         = 32;
    localparam int ARCH_REG_IDX    = 4;
    localparam int PHYS_REG_IDX    = 5;
    localparam int NUM_ROB_ENTRIES = 16;
    localparam int ROB_IDX_W       = $clog2(NUM_ROB_ENTRIES);

    typedef struct packed {
        logic                     valid;
        logic                     is_store;
        logic [2:0]               funct3;
        logic [RV_XLEN-1:0]       imm;
        logic [PHYS_REG_IDX:0]    ps1;
        logic [PHYS_REG_IDX:0]    ps2;
        logic                     rdy1;
        logic                     rdy2;
        logic [RV_XLEN-1:0]       val1;
        logic [RV_XLEN-1:0]       val2;
        logic [ARCH_REG_IDX:0]    rd_arch;
        logic [PHYS_REG_IDX:0]    pd;
        logic [ROB_IDX_W-1:0]     rob_idx;
        logic                     dest_we;
    } mem_q_entry_t;

endpackage

// File: rtl/mem_op_queue.sv
// In-order load/store queue: captures operands from the CDB and issues the head
// entry to a single-outstanding LSU; stores wait until they are at the ROB head.
module mem_op_queue
    import rv32i_types::*;
#(
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                         clk,
    input  logic                         rst,

    input  logic                         enq_valid,
    output logic                         enq_ready,
    input  logic                         enq_is_store,
    input  logic [2:0]                   enq_funct3,
    input  logic [XLEN-1:0]              enq_imm,
    input  logic [PHYS_REG_IDX:0]        enq_ps1,
    input  logic [PHYS_REG_IDX:0]        enq_ps2,
    input  logic                         enq_ps1_rdy,
    input  logic                         enq_ps2_rdy,
    input  logic [XLEN-1:0]              enq_ps1_val,
    input  logic [XLEN-1:0]              enq_ps2_val,
    input  logic [ARCH_REG_IDX:0]        enq_rd_arch,
    input  logic [PHYS_REG_IDX:0]        enq_pd,
    input  logic [ROB_IDX_W-1:0]         enq_rob_idx,
    input  logic                         enq_dest_we,

    input  logic                         cdb_valid,
    input  logic [PHYS_REG_IDX:0]        cdb_pd,
    input  logic [XLEN-1:0]              cdb_value,

    input  logic                         rob_head_valid,
    input  logic [ROB_IDX_W-1:0]         rob_head_idx,

    input  logic                         flush,

    output logic                         lsu_req_valid,
    input  logic                         lsu_req_ready,
    output logic [XLEN-1:0]              lsu_base_addr,
    output logic [XLEN-1:0]              lsu_offset,
    output logic [XLEN-1:0]              lsu_store_data,
    output logic [2:0]                   lsu_funct3,
    output logic                         lsu_is_store,
    output logic [ARCH_REG_IDX:0]        lsu_rd_arch,
    output logic [PHYS_REG_IDX:0]        lsu_pd_phys,
    output logic [ROB_IDX_W-1:0]         lsu_rob_idx,
    output logic                         lsu_dest_we,

    output logic [$clog2(DEPTH):0]       count,
    output logic                         empty,
    output logic                         full
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;

    mem_q_entry_t     mem_q [DEPTH];
    mem_q_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;

    mem_q_entry_t     head_e;
    mem_q_entry_t     enq_e;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] tail_idx;
    logic             load_ok;
    logic             store_ok;
    logic             enq_fire;
    logic             issue_fire;

    assign head_idx = head_q[IDX_W-1:0];
    assign tail_idx = tail_q[IDX_W-1:0];
    assign head_e   = mem_q[head_idx];

    assign full  = (head_idx == tail_idx) && (head_q[PTR_W-1] != tail_q[PTR_W-1]);
    assign empty = (head_q == tail_q);
    assign count = tail_q - head_q;

    assign enq_ready = !full && !flush;
    assign enq_fire  = enq_valid && enq_ready;

    // Stores only go out once they are non-speculative (at the ROB head).
    assign load_ok  = head_e.valid && !head_e.is_store && head_e.rdy1;
    assign store_ok = head_e.valid && head_e.is_store && head_e.rdy1 && head_e.rdy2
                      && rob_head_valid && (head_e.rob_idx == rob_head_idx);

    assign lsu_req_valid = (load_ok || store_ok) && !flush;
    assign issue_fire    = lsu_req_valid && lsu_req_ready;

    assign lsu_base_addr  = head_e.val1;
    assign lsu_offset     = head_e.imm;
    assign lsu_store_data = head_e.is_store ? head_e.val2 : '0;
    assign lsu_funct3     = head_e.funct3;
    assign lsu_is_store   = head_e.is_store;
    assign lsu_rd_arch    = head_e.rd_arch;
    assign lsu_pd_phys    = head_e.pd;
    assign lsu_rob_idx    = head_e.rob_idx;
    assign lsu_dest_we    = head_e.dest_we && !head_e.is_store;

    // New entry, including a same-cycle CDB bypass for sources not yet ready.
    always_comb begin
        enq_e          = '0;
        enq_e.valid    = 1'b1;
        enq_e.is_store = enq_is_store;
        enq_e.funct3   = enq_funct3;
        enq_e.imm      = enq_imm;
        enq_e.ps1      = enq_ps1;
        enq_e.ps2      = enq_ps2;
        enq_e.rdy1     = enq_ps1_rdy;
        enq_e.rdy2     = enq_ps2_rdy;
        enq_e.val1     = enq_ps1_val;
        enq_e.val2     = enq_ps2_val;
        enq_e.rd_arch  = enq_rd_arch;
        enq_e.pd       = enq_pd;
        enq_e.rob_idx  = enq_rob_idx;
        enq_e.dest_we  = enq_dest_we;
        if (!enq_ps1_rdy && cdb_valid && (cdb_pd == enq_ps1)) begin
            enq_e.rdy1 = 1'b1;
            enq_e.val1 = cdb_value;
        end
        if (!enq_ps2_rdy && cdb_valid && (cdb_pd == enq_ps2)) begin
            enq_e.rdy2 = 1'b1;
            enq_e.val2 = cdb_value;
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
            if (mem_q[i].valid && cdb_valid) begin
                if (!mem_q[i].rdy1 && (mem_q[i].ps1 == cdb_pd)) begin
                    mem_d[i].rdy1 = 1'b1;
                    mem_d[i].val1 = cdb_value;
                end
                if (!mem_q[i].rdy2 && (mem_q[i].ps2 == cdb_pd)) begin
                    mem_d[i].rdy2 = 1'b1;
                    mem_d[i].val2 = cdb_value;
                end
            end
        end
        head_d = head_q;
        tail_d = tail_q;
        if (issue_fire) begin
            mem_d[head_idx].valid = 1'b0;
            head_d                = head_q + 1'b1;
        end
        // Tail slot never aliases a valid head: enqueue is refused when full.
        if (enq_fire) begin
            mem_d[tail_idx] = enq_e;
            tail_d          = tail_q + 1'b1;
        end
        if (flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_d[i].valid = 1'b0;
            end
            head_d = '0;
            tail_d = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head_q <= '0;
            tail_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= mem_d[i];
            end
        end
    end

endmodule

// File: tb/tb_mem_op_queue.sv
// Scoreboard bench for mem_op_queue: directed ops push expected LSU requests,
// a negedge monitor pops and compares on each accepted handshake.
module tb_mem_op_queue;
    import rv32i_types::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        enq_valid, enq_ready, enq_is_store;
    logic [2:0]  enq_funct3;
    logic [31:0] enq_imm, enq_ps1_val, enq_ps2_val;
    logic [5:0]  enq_ps1, enq_ps2, enq_pd;
    logic        enq_ps1_rdy, enq_ps2_rdy, enq_dest_we;
    logic [4:0]  enq_rd_arch;
    logic [3:0]  enq_rob_idx;
    logic        cdb_valid;
    logic [5:0]  cdb_pd;
    logic [31:0] cdb_value;
    logic        rob_head_valid;
    logic [3:0]  rob_head_idx;
    logic        flush;
    logic        lsu_req_valid, lsu_req_ready;
    logic [31:0] lsu_base_addr, lsu_offset, lsu_store_data;
    logic [2:0]  lsu_funct3;
    logic        lsu_is_store, lsu_dest_we;
    logic [4:0]  lsu_rd_arch;
    logic [5:0]  lsu_pd_phys;
    logic [3:0]  lsu_rob_idx;
    logic [3:0]  count;
    logic        empty, full;

    mem_op_queue #(.DEPTH(8), .XLEN(32)) dut (
        .clk(clk), .rst(rst),
        .enq_valid(enq_valid), .enq_ready(enq_ready), .enq_is_store(enq_is_store),
        .enq_funct3(enq_funct3), .enq_imm(enq_imm),
        .enq_ps1(enq_ps1), .enq_ps2(enq_ps2),
        .enq_ps1_rdy(enq_ps1_rdy), .enq_ps2_rdy(enq_ps2_rdy),
        .enq_ps1_val(enq_ps1_val), .enq_ps2_val(enq_ps2_val),
        .enq_rd_arch(enq_rd_arch), .enq_pd(enq_pd), .enq_rob_idx(enq_rob_idx),
        .enq_dest_we(enq_dest_we),
        .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .cdb_value(cdb_value),
        .rob_head_valid(rob_head_valid), .rob_head_idx(rob_head_idx),
        .flush(flush),
        .lsu_req_valid(lsu_req_valid), .lsu_req_ready(lsu_req_ready),
        .lsu_base_addr(lsu_base_addr), .lsu_offset(lsu_offset),
        .lsu_store_data(lsu_store_data), .lsu_funct3(lsu_funct3),
        .lsu_is_store(lsu_is_store), .lsu_rd_arch(lsu_rd_arch),
        .lsu_pd_phys(lsu_pd_phys), .lsu_rob_idx(lsu_rob_idx),
        .lsu_dest_we(lsu_dest_we),
        .count(count), .empty(empty), .full(full)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] base;
        logic [31:0] off;
        logic [31:0] sdata;
        logic [2:0]  f3;
        logic        st;
        logic [4:0]  rd;
        logic [5:0]  pd;
        logic [3:0]  rob;
        logic        we;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end else begin
            $display("ok   %s: 0x%0h", name, act);
        end
    endtask

    task automatic expect_op(input logic [31:0] base, input logic [31:0] off,
                             input logic [31:0] sdata, input logic [2:0] f3,
                             input logic st, input logic [4:0] rd, input logic [5:0] pd,
                             input logic [3:0] rob, input logic we);
        exp_t e;
        e.base = base; e.off = off; e.sdata = sdata; e.f3 = f3; e.st = st;
        e.rd = rd; e.pd = pd; e.rob = rob; e.we = we;
        exp_q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic enq(input logic st, input logic [2:0] f3, input logic [31:0] imm,
                       input logic [5:0] ps1, input logic r1, input logic [31:0] v1,
                       input logic [5:0] ps2, input logic r2, input logic [31:0] v2,
                       input logic [4:0] rd, input logic [5:0] pd,
                       input logic [3:0] rob, input logic we);
        enq_is_store = st; enq_funct3 = f3; enq_imm = imm;
        enq_ps1 = ps1; enq_ps1_rdy = r1; enq_ps1_val = v1;
        enq_ps2 = ps2; enq_ps2_rdy = r2; enq_ps2_val = v2;
        enq_rd_arch = rd; enq_pd = pd; enq_rob_idx = rob; enq_dest_we = we;
        enq_valid = 1'b1;
        tick();
        enq_valid = 1'b0;
    endtask

    // Monitor: every accepted request must match the oldest expected one.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && lsu_req_valid && lsu_req_ready) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_issue: got base 0x%0h, expected no request",
                             lsu_base_addr);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    $display("txn  issue base=0x%0h off=0x%0h st=%0b", lsu_base_addr,
                             lsu_offset, lsu_is_store);
                    chk("lsu_base", lsu_base_addr, e.base);
                    chk("lsu_offset", lsu_offset, e.off);
                    chk("lsu_sdata", lsu_store_data, e.sdata);
                    chk("lsu_funct3", {29'd0, lsu_funct3}, {29'd0, e.f3});
                    chk("lsu_is_store", {31'd0, lsu_is_store}, {31'd0, e.st});
                    chk("lsu_rd", {27'd0, lsu_rd_arch}, {27'd0, e.rd});
                    chk("lsu_pd", {26'd0, lsu_pd_phys}, {26'd0, e.pd});
                    chk("lsu_rob", {28'd0, lsu_rob_idx}, {28'd0, e.rob});
                    chk("lsu_dest_we", {31'd0, lsu_dest_we}, {31'd0, e.we});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        enq_valid = 0; enq_is_store = 0; enq_funct3 = 0; enq_imm = 0;
        enq_ps1 = 0; enq_ps2 = 0; enq_ps1_rdy = 0; enq_ps2_rdy = 0;
        enq_ps1_val = 0; enq_ps2_val = 0; enq_rd_arch = 0; enq_pd = 0;
        enq_rob_idx = 0; enq_dest_we = 0;
        cdb_valid = 0; cdb_pd = 0; cdb_value = 0;
        rob_head_valid = 0; rob_head_idx = 0; flush = 0; lsu_req_ready = 0;

        // Reset state
        tick(); tick();
        @(negedge clk);
        chk("rst_count", {28'd0, count}, 32'd0);
        chk("rst_empty", {31'd0, empty}, 32'd1);
        chk("rst_full", {31'd0, full}, 32'd0);
        chk("rst_req_valid", {31'd0, lsu_req_valid}, 32'd0);
        chk("rst_base", lsu_base_addr, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_enq_ready", {31'd0, enq_ready}, 32'd1);
        chk("post_rst_req_valid", {31'd0, lsu_req_valid}, 32'd0);
        chk("post_rst_sdata", lsu_store_data, 32'd0);
        tick();

        // Ready load issues the next cycle
        lsu_req_ready = 1'b1;
        expect_op(32'h1000, 32'd4, 32'd0, 3'd2, 1'b0, 5'd5, 6'd33, 4'd0, 1'b1);
        enq(1'b0, 3'd2, 32'd4, 6'd1, 1'b1, 32'h1000, 6'd0, 1'b1, 32'd0, 5'd5, 6'd33, 4'd0, 1'b1);
        @(negedge clk);
        chk("lw_latency_valid", {31'd0, lsu_req_valid}, 32'd1);
        tick(); tick();
        @(negedge clk);
        chk("lw_count_after", {28'd0, count}, 32'd0);
        tick();

        // Store waits for the ROB head
        rob_head_valid = 1'b1;
        rob_head_idx   = 4'd3;
        enq(1'b1, 3'd2, 32'd8, 6'd2, 1'b1, 32'h3000, 6'd3, 1'b1, 32'hDEADBEEF, 5'd0, 6'd0, 4'd5, 1'b1);
        tick(); tick();
        @(negedge clk);
        chk("sw_held_valid", {31'd0, lsu_req_valid}, 32'd0);
        chk("sw_held_count", {28'd0, count}, 32'd1);
        tick();
        expect_op(32'h3000, 32'd8, 32'hDEADBEEF, 3'd2, 1'b1, 5'd0, 6'd0, 4'd5, 1'b0);
        rob_head_idx = 4'd5;
        @(negedge clk);
        chk("sw_rob_head_valid", {31'd0, lsu_req_valid}, 32'd1);
        tick(); tick();
        rob_head_valid = 1'b0;

        // CDB wakeup after enqueue
        enq(1'b0, 3'd0, 32'h10, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 5'd6, 6'd40, 4'd1, 1'b1);
        tick();
        @(negedge clk);
        chk("wake_wait_valid", {31'd0, lsu_req_valid}, 32'd0);
        tick();
        expect_op(32'h2000, 32'h10, 32'd0, 3'd0, 1'b0, 5'd6, 6'd40, 4'd1, 1'b1);
        cdb_valid = 1'b1; cdb_pd = 6'd12; cdb_value = 32'h2000;
        tick();
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("wake_next_valid", {31'd0, lsu_req_valid}, 32'd1);
        tick(); tick();

        // CDB match in the enqueue cycle itself
        expect_op(32'h2000, 32'h14, 32'd0, 3'd4, 1'b0, 5'd7, 6'd41, 4'd2, 1'b1);
        cdb_valid = 1'b1; cdb_pd = 6'd12; cdb_value = 32'h2000;
        enq(1'b0, 3'd4, 32'h14, 6'd12, 1'b0, 32'd0, 6'd0, 1'b1, 32'd0, 5'd7, 6'd41, 4'd2, 1'b1);
        cdb_valid = 1'b0;
        @(negedge clk);
        chk("bypass_valid", {31'd0, lsu_req_valid}, 32'd1);
        tick(); tick();

        // Fill across the wrap point with the LSU stalled
        lsu_req_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            expect_op(32'h100 * (i + 1), i, 32'd0, 3'd2, 1'b0, 5'(i), 6'(i + 8), 4'(i), 1'b1);
            enq(1'b0, 3'd2, i, 6'd9, 1'b1, 32'h100 * (i + 1), 6'd0, 1'b1, 32'd0,
                5'(i), 6'(i + 8), 4'(i), 1'b1);
        end
        @(negedge clk);
        chk("fill_full", {31'd0, full}, 32'd1);
        chk("fill_enq_ready", {31'd0, enq_ready}, 32'd0);
        chk("fill_count", {28'd0, count}, 32'd8);
        tick();
        // Full queue refuses enqueue even while issuing
        lsu_req_ready = 1'b1;
        enq(1'b0, 3'd2, 32'd0, 6'd9, 1'b1, 32'hBAD, 6'd0, 1'b1, 32'd0, 5'd0, 6'd0, 4'd0, 1'b1);
        @(negedge clk);
        chk("full_issue_count", {28'd0, count}, 32'd7);
        for (int i = 0; i < 10; i++) tick();
        @(negedge clk);
        chk("drain_empty", {31'd0, empty}, 32'd1);
        chk("drain_count", {28'd0, count}, 32'd0);
        chk("drain_sb_empty", exp_q.size(), 32'd0);
        tick();

        // Flush with three held entries
        lsu_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            enq(1'b0, 3'd0, 32'd0, 6'd9, 1'b1, 32'h4000 + i, 6'd0, 1'b1, 32'd0,
                5'd1, 6'd1, 4'd1, 1'b1);
        end
        @(negedge clk);
        chk("pre_flush_count", {28'd0, count}, 32'd3);
        tick();
        lsu_req_ready = 1'b1;
        flush = 1'b1;
        @(negedge clk);
        chk("flush_req_valid", {31'd0, lsu_req_valid}, 32'd0);
        chk("flush_enq_ready", {31'd0, enq_ready}, 32'd0);
        tick();
        flush = 1'b0;
        @(negedge clk);
        chk("post_flush_count", {28'd0, count}, 32'd0);
        chk("post_flush_valid", {31'd0, lsu_req_valid}, 32'd0);
        chk("post_flush_empty", {31'd0, empty}, 32'd1);
        tick();
        expect_op(32'h5000, 32'h8, 32'd0, 3'd1, 1'b0, 5'd3, 6'd20, 4'd7, 1'b0);
        enq(1'b0, 3'd1, 32'h8, 6'd9, 1'b1, 32'h5000, 6'd0, 1'b1, 32'd0, 5'd3, 6'd20, 4'd7, 1'b0);
        tick(); tick();

        // Asynchronous reset mid-fill
        lsu_req_ready = 1'b0;
        enq(1'b0, 3'd0, 32'd0, 6'd9, 1'b1, 32'h6000, 6'd0, 1'b1, 32'd0, 5'd1, 6'd1, 4'd1, 1'b1);
        enq(1'b0, 3'd0, 32'd0, 6'd9, 1'b1, 32'h6004, 6'd0, 1'b1, 32'd0, 5'd1, 6'd1, 4'd1, 1'b1);
        @(negedge clk);
        chk("pre_rst_count", {28'd0, count}, 32'd2);
        #2;
        rst = 1'b1;
        #1;
        chk("async_rst_count", {28'd0, count}, 32'd0);
        chk("async_rst_valid", {31'd0, lsu_req_valid}, 32'd0);
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("rerst_enq_ready", {31'd0, enq_ready}, 32'd1);
        chk("rerst_empty", {31'd0, empty}, 32'd1);
        chk("rerst_base", lsu_base_addr, 32'd0);
        tick(); tick();
        chk("final_sb_empty", exp_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_op_queue.md
# mem_op_queue

In-order memory-operation queue and issue controller that sits between rename/dispatch and the single-outstanding `lsu`. It buffers loads and stores in program order and captures source operands from the CDB. It issues the oldest entry to the LSU over its `req_valid`/`req_ready` handshake once operands are ready. Stores are additionally held until they reach the ROB head, so memory is never written speculatively.

## Interface
- `DEPTH`, 8: queue entries; power of two, ≥2.
- `XLEN`, 32: data width.
- `clk` in 1: clock.
- `rst` in 1: reset, asynchronous, active-high.
- `enq_valid` / `enq_ready`, in / out, 1 each: dispatch handshake.
- `enq_is_store` in 1, `enq_funct3` in 3, `enq_imm` in XLEN.
- `enq_ps1`, `enq_ps2` in PHYS_REG_IDX+1: source tags.
- `enq_ps1_rdy`, `enq_ps2_rdy` in 1, `enq_ps1_val`, `enq_ps2_val` in XLEN: operand state at dispatch.
- `enq_rd_arch` in ARCH_REG_IDX+1, `enq_pd` in PHYS_REG_IDX+1, `enq_rob_idx` in $clog2(NUM_ROB_ENTRIES), `enq_dest_we` in 1.
- `cdb_valid` in 1, `cdb_pd` in PHYS_REG_IDX+1, `cdb_value` in XLEN: writeback broadcast.
- `rob_head_valid` in 1, `rob_head_idx` in $clog2(NUM_ROB_ENTRIES): current oldest uncommitted instruction.
- `flush` in 1: discard all entries.
- `lsu_req_valid` out 1, `lsu_req_ready` in 1.
- `lsu_base_addr`, `lsu_offset`, `lsu_store_data` out XLEN.
- `lsu_funct3` out 3, `lsu_is_store` out 1, `lsu_rd_arch`, `lsu_pd_phys`, `lsu_rob_idx`, `lsu_dest_we` out: widths as the matching `enq_*` ports.
- `count` out $clog2(DEPTH)+1, `empty` out 1, `full` out 1.

## Operation
- Circular buffer with `head`/`tail` pointers of $clog2(DEPTH)+1 bits; the MSB is the wrap bit.
  - `full` = index bits equal and wrap bits differ.
  - `empty` = `head == tail`.
  - `count` = `tail - head` (modular).
- Enqueue:
  - `enq_ready = !full && !flush`.
  - On `enq_valid && enq_ready`, the entry is written at `tail` and `tail` increments.
  - Operand capture per source: if `enq_psN_rdy`, take `enq_psN_val`; else if `cdb_valid && cdb_pd == enq_psN`, mark ready and take `cdb_value`; else mark not ready.
- Wakeup: every valid entry with a not-ready source whose tag equals `cdb_pd` while `cdb_valid` is high captures `cdb_value` and sets ready.
- Issue applies to the `head` entry only (strict program order).
  - Load eligible: valid and rs1 ready.
  - Store eligible: valid, rs1 and rs2 ready, `rob_head_valid`, and `rob_idx == rob_head_idx`.
  - `lsu_req_valid` = eligible && !`flush`.
  - `lsu_*` fields are driven from the head entry:
    - base = rs1 value; offset = imm.
    - store_data = rs2 value for stores, 0 for loads.
    - `lsu_dest_we` = entry dest_we && !is_store.
  - On `lsu_req_valid && lsu_req_ready`, `head` increments.
- Flush:
  - All entry valid bits clear and `head = tail = 0` at the next edge.
  - Enqueue and issue are both suppressed in the flush cycle.
  - An op already accepted by the LSU is not recalled.
- Simultaneous enqueue and issue in one cycle is allowed. When full, enqueue is refused even if issue fires that cycle; there is no pass-through.

## Timing
- During `rst`, and the cycle after its release:
  - `enq_ready = 1` (after release).
  - `lsu_req_valid = 0`, `count = 0`, `empty = 1`, `full = 0`.
  - All `lsu_*` data outputs are 0.
- Minimum latency from enqueue (edge N) to `lsu_req_valid` is cycle N+1, provided operands were ready or woken by the CDB at enqueue.
- A CDB wakeup at edge N makes the head eligible in cycle N+1.
- Outputs depend only on flops plus `rob_head_*`, `flush`, and `lsu_req_ready`; there is no combinational path from `enq_*` or `cdb_*` to `lsu_*`.
- `lsu_req_valid` stays high and the fields stay stable until accepted, unless a flush occurs.
- Pointer wrap: after DEPTH enqueues, `tail` index returns to 0 and the wrap bit toggles; `full`/`empty` remain correct.
- A reset asserted mid-operation clears everything asynchronously.

## Structure
- Add `mem_q_entry_t` to `rv32i_types`. Fields: valid, is_store, funct3, imm, ps1/ps2, rdy1/rdy2, val1/val2, rd_arch, pd, rob_idx, dest_we.
- Single module with no sub-modules. Entry storage is a flop array of `mem_q_entry_t`, with the same async-reset flop style for every register.

## Test plan
- Enqueue `lw` with rs1 ready (base 0x1000, imm 4), LSU ready → `lsu_req_valid` in the next cycle with base 0x1000 and offset 4; the entry pops and `count` returns to 0.
- Enqueue `sw` with rob_idx 5 and operands ready while `rob_head_idx = 3` → no issue. Drive `rob_head_idx = 5` → issue with `lsu_is_store = 1` and `lsu_dest_we = 0`.
- Enqueue a load with rs1 not ready (ps1 = 12), then `cdb_valid` with pd 12 and value 0x2000 → issue next cycle with base 0x2000. Repeat with the CDB matching in the enqueue cycle itself → same result.
- Fill 8 entries with `lsu_req_ready = 0` → `full = 1` and `enq_ready = 0`. Drain all entries across the wrap point → order preserved and `empty = 1`.
- With 3 entries held, assert `flush` while `lsu_req_ready = 1` → no handshake in that cycle, then `count = 0` and `lsu_req_valid = 0`.
- Assert `rst` mid-fill → `count = 0` immediately, and `enq_ready = 1` after release.
